pipeline_hazard_controller: RTL and testbench

- Sequences the 5-stage LEGv8 pipeline: detects read-after-write register hazards between the ID instruction and in-flight producers, then stalls PC and IF/ID while inserting bubbles into ID/EX.
- Sequences taken-branch flushes, resolved in EX from the zero & branch condition, through a small FSM.
- Keeps saturating stall and flush statistics counters.
- Sits beside the Controller; its outputs gate the PC register, IF/ID register enables/clears and ID/EX control clears.

---
 rtl/pipeline_hazard_controller.sv | 139 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard and flush sequencer for the 5-stage LEGv8 pipeline: stalls PC/IF-ID on
// RAW hazards, flushes on taken branches, and keeps saturating statistics.
module pipeline_hazard_controller #(
    parameter int RF_BYPASS    = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       ifid_rn,
    input  logic [4:0]       ifid_rm,
    input  logic             ifid_uses_rn,
    input  logic             ifid_uses_rm,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       exmem_rd,
    input  logic [4:0]       memwb_rd,
    input  logic             idex_regwrite,
    input  logic             exmem_regwrite,
    input  logic             memwb_regwrite,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_FLUSH      = 2'd1;
    localparam logic [1:0] ST_RESET_HOLD = 2'd2;

    // The detect cycle counts as the first flush cycle, so FLUSH is entered with two fewer remaining.
    localparam int         FLUSH_LOAD_INT = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;
    localparam logic [3:0] FLUSH_LOAD     = FLUSH_LOAD_INT[3:0];
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]       state_q, state_d;
    logic [3:0]       flushLeft_q, flushLeft_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
    logic             stallInc, flushInc;
    logic             matchEx, matchMem, matchWb, hazard;

    function automatic logic producerMatch(
        input logic       we,
        input logic [4:0] rd,
        input logic       useRn,
        input logic [4:0] rn,
        input logic       useRm,
        input logic [4:0] rm
    );
        return we && (rd != 5'd31) && ((useRn && (rd == rn)) || (useRm && (rd == rm)));
    endfunction

    assign matchEx  = producerMatch(idex_regwrite, idex_rd, ifid_uses_rn, ifid_rn,
                                    ifid_uses_rm, ifid_rm);
    assign matchMem = producerMatch(exmem_regwrite, exmem_rd, ifid_uses_rn, ifid_rn,
                                    ifid_uses_rm, ifid_rm);
    assign matchWb  = producerMatch(memwb_regwrite, memwb_rd, ifid_uses_rn, ifid_rn,
                                    ifid_uses_rm, ifid_rm);
    // With a write-through register bank the WB producer is already visible to ID.
    assign hazard   = matchEx || matchMem || ((RF_BYPASS == 0) && matchWb);

    always_comb begin
        state_d     = state_q;
        flushLeft_d = flushLeft_q;
        stallInc    = 1'b0;
        flushInc    = 1'b0;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        case (state_q)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    flushInc   = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        flushLeft_d = FLUSH_LOAD;
                    end
                end else if (hazard) begin
                    ifid_flush = 1'b0;
                    stallInc   = 1'b1;
                end else begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    ifid_flush  = 1'b0;
                    idex_bubble = 1'b0;
                end
            end
            ST_FLUSH: begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                if (flushLeft_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    flushLeft_d = flushLeft_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (stallInc && (stallCnt_q != CNT_MAX)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
        if (flushInc && (flushCnt_q != CNT_MAX)) begin
            flushCnt_d = flushCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RESET_HOLD;
            flushLeft_q <= 4'd0;
            stallCnt_q  <= '0;
            flushCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            flushLeft_q <= flushLeft_d;
            stallCnt_q  <= stallCnt_d;
            flushCnt_q  <= flushCnt_d;
        end
    end

    assign state       = state_q;
    assign stall_count = stallCnt_q;
    assign flush_count = flushCnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: a default instance (A) and a
// RF_BYPASS=0 / FLUSH_CYCLES=3 / CNT_W=4 instance (B) share one stimulus stream.
module tb_pipeline_hazard_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] ifidRn, ifidRm, idexRd, exmemRd, memwbRd;
    logic       ifidUsesRn, ifidUsesRm;
    logic       idexRegwrite, exmemRegwrite, memwbRegwrite, exBranchTaken;

    logic        pcWriteA, ifidWriteA, ifidFlushA, idexBubbleA;
    logic [1:0]  stateA;
    logic [15:0] stallCountA, flushCountA;
    logic        pcWriteB, ifidWriteB, ifidFlushB, idexBubbleB;
    logic [1:0]  stateB;
    logic [3:0]  stallCountB, flushCountB;

    int nCompared   = 0;
    int nMismatched = 0;

    // Model state per instance: in reset-hold, remaining forced-flush cycles, counters.
    int mHold[2];
    int mFlushLeft[2];
    int mStall[2];
    int mFlushCnt[2];

    typedef struct {
        logic [4:0] rn, rm, exRd, memRd, wbRd;
        logic       useRn, useRm, exWe, memWe, wbWe;
        logic [3:0] expA, expB;
        int         expStallA, expStallB;
    } vec_t;

    vec_t vecs[10];

    always #5 clock = ~clock;

    pipeline_hazard_controller dutA (
        .clock(clock), .reset(reset),
        .ifid_rn(ifidRn), .ifid_rm(ifidRm),
        .ifid_uses_rn(ifidUsesRn), .ifid_uses_rm(ifidUsesRm),
        .idex_rd(idexRd), .exmem_rd(exmemRd), .memwb_rd(memwbRd),
        .idex_regwrite(idexRegwrite), .exmem_regwrite(exmemRegwrite),
        .memwb_regwrite(memwbRegwrite), .ex_branch_taken(exBranchTaken),
        .pc_write(pcWriteA), .ifid_write(ifidWriteA), .ifid_flush(ifidFlushA),
        .idex_bubble(idexBubbleA), .state(stateA),
        .stall_count(stallCountA), .flush_count(flushCountA)
    );

    pipeline_hazard_controller #(.RF_BYPASS(0), .FLUSH_CYCLES(3), .CNT_W(4)) dutB (
        .clock(clock), .reset(reset),
        .ifid_rn(ifidRn), .ifid_rm(ifidRm),
        .ifid_uses_rn(ifidUsesRn), .ifid_uses_rm(ifidUsesRm),
        .idex_rd(idexRd), .exmem_rd(exmemRd), .memwb_rd(memwbRd),
        .idex_regwrite(idexRegwrite), .exmem_regwrite(exmemRegwrite),
        .memwb_regwrite(memwbRegwrite), .ex_branch_taken(exBranchTaken),
        .pc_write(pcWriteB), .ifid_write(ifidWriteB), .ifid_flush(ifidFlushB),
        .idex_bubble(idexBubbleB), .state(stateB),
        .stall_count(stallCountB), .flush_count(flushCountB)
    );

    function automatic int rfBypass(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic int flushCycles(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int cntMax(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    function automatic bit modelHazard(input int k);
        int rds[3];
        bit wes[3];
        rds[0] = int'(idexRd);  wes[0] = idexRegwrite;
        rds[1] = int'(exmemRd); wes[1] = exmemRegwrite;
        rds[2] = int'(memwbRd); wes[2] = memwbRegwrite;
        for (int p = 0; p < 3; p++) begin
            if (p == 2 && rfBypass(k) == 1) continue;
            if (wes[p] && rds[p] != 31 &&
                ((ifidUsesRn && rds[p] == int'(ifidRn)) ||
                 (ifidUsesRm && rds[p] == int'(ifidRm))))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    // Expected {pc_write, ifid_write, ifid_flush, idex_bubble}.
    function automatic int modelOuts(input int k);
        if (mHold[k] != 0)     return 4'b0011;
        if (mFlushLeft[k] > 0) return 4'b1111;
        if (exBranchTaken)     return 4'b1111;
        if (modelHazard(k))    return 4'b0001;
        return 4'b1100;
    endfunction

    function automatic int modelState(input int k);
        if (mHold[k] != 0)     return 2;
        if (mFlushLeft[k] > 0) return 1;
        return 0;
    endfunction

    task automatic modelEdge();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mHold[k] = 1; mFlushLeft[k] = 0; mStall[k] = 0; mFlushCnt[k] = 0;
            end else if (mHold[k] != 0) begin
                mHold[k] = 0;
            end else if (mFlushLeft[k] > 0) begin
                mFlushLeft[k]--;
            end else if (exBranchTaken) begin
                if (mFlushCnt[k] < cntMax(k)) mFlushCnt[k]++;
                mFlushLeft[k] = flushCycles(k) - 1;
            end else if (modelHazard(k)) begin
                if (mStall[k] < cntMax(k)) mStall[k]++;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int outsA();
        return {28'd0, pcWriteA, ifidWriteA, ifidFlushA, idexBubbleA};
    endfunction

    function automatic int outsB();
        return {28'd0, pcWriteB, ifidWriteB, ifidFlushB, idexBubbleB};
    endfunction

    task automatic checkOutput(input string tag);
        check({tag, " A outs"},  outsA(), modelOuts(0));
        check({tag, " A state"}, int'(stateA), modelState(0));
        check({tag, " A stall"}, int'(stallCountA), mStall[0]);
        check({tag, " A flush"}, int'(flushCountA), mFlushCnt[0]);
        check({tag, " B outs"},  outsB(), modelOuts(1));
        check({tag, " B state"}, int'(stateB), modelState(1));
        check({tag, " B stall"}, int'(stallCountB), mStall[1]);
        check({tag, " B flush"}, int'(flushCountB), mFlushCnt[1]);
    endtask

    task automatic atNegedge(input string tag);
        @(negedge clock);
        checkOutput(tag);
    endtask

    task automatic finishCycle();
        @(posedge clock);
        modelEdge();
        #1;
    endtask

    task automatic runCycle(input string tag);
        atNegedge(tag);
        finishCycle();
    endtask

    task automatic setIdle();
        ifidRn = 5'd0; ifidRm = 5'd0; ifidUsesRn = 1'b0; ifidUsesRm = 1'b0;
        idexRd = 5'd0; exmemRd = 5'd0; memwbRd = 5'd0;
        idexRegwrite = 1'b0; exmemRegwrite = 1'b0; memwbRegwrite = 1'b0;
        exBranchTaken = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        ifidRn = v.rn; ifidRm = v.rm; ifidUsesRn = v.useRn; ifidUsesRm = v.useRm;
        idexRd = v.exRd; exmemRd = v.memRd; memwbRd = v.wbRd;
        idexRegwrite = v.exWe; exmemRegwrite = v.memWe; memwbRegwrite = v.wbWe;
        exBranchTaken = 1'b0;
    endtask

    function automatic vec_t mkVec(
        input int rn, input int useRn, input int rm, input int useRm,
        input int exRd, input int exWe, input int memRd, input int memWe,
        input int wbRd, input int wbWe, input int expA, input int expB,
        input int stA, input int stB
    );
        vec_t v;
        v.rn = 5'(rn); v.useRn = 1'(useRn); v.rm = 5'(rm); v.useRm = 1'(useRm);
        v.exRd = 5'(exRd); v.exWe = 1'(exWe); v.memRd = 5'(memRd); v.memWe = 1'(memWe);
        v.wbRd = 5'(wbRd); v.wbWe = 1'(wbWe);
        v.expA = 4'(expA); v.expB = 4'(expB);
        v.expStallA = stA; v.expStallB = stB;
        return v;
    endfunction

    function automatic logic [4:0] rndReg();
        int r;
        r = int'($urandom_range(0, 4));
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        // Load-use X2 drains EX -> MEM -> WB, then XZR/unused-operand/WB-only cases.
        vecs[0] = mkVec(2, 1, 0, 0,  2, 1, 0, 0, 0, 0,  4'b0001, 4'b0001, 0, 0);
        vecs[1] = mkVec(2, 1, 0, 0,  0, 0, 2, 1, 0, 0,  4'b0001, 4'b0001, 1, 1);
        vecs[2] = mkVec(2, 1, 0, 0,  0, 0, 0, 0, 2, 1,  4'b1100, 4'b0001, 2, 2);
        vecs[3] = mkVec(2, 1, 0, 0,  0, 0, 0, 0, 0, 0,  4'b1100, 4'b1100, 2, 3);
        vecs[4] = mkVec(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  4'b1100, 4'b1100, 2, 3);
        vecs[5] = mkVec(31, 1, 0, 0, 31, 1, 0, 0, 0, 0, 4'b1100, 4'b1100, 2, 3);
        vecs[6] = mkVec(3, 1, 5, 0,  5, 1, 0, 0, 0, 0,  4'b1100, 4'b1100, 2, 3);
        vecs[7] = mkVec(3, 1, 5, 1,  5, 1, 0, 0, 0, 0,  4'b0001, 4'b0001, 2, 3);
        vecs[8] = mkVec(7, 1, 0, 0,  0, 0, 0, 0, 7, 1,  4'b1100, 4'b0001, 3, 4);
        vecs[9] = mkVec(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  4'b1100, 4'b1100, 3, 5);

        for (int k = 0; k < 2; k++) begin
            mHold[k] = 0; mFlushLeft[k] = 0; mStall[k] = 0; mFlushCnt[k] = 0;
        end
        setIdle();
        reset = 1'b1;
        finishCycle();

        for (int i = 0; i < 2; i++) begin
            atNegedge("reset");
            check("reset A state", int'(stateA), 2);
            check("reset A pc_write", int'(pcWriteA), 0);
            check("reset B stall", int'(stallCountB), 0);
            finishCycle();
        end
        reset = 1'b0;
        atNegedge("release");
        check("release state still hold", int'(stateA), 2);
        finishCycle();
        atNegedge("run");
        check("run A state", int'(stateA), 0);
        check("run A pc_write", int'(pcWriteA), 1);
        finishCycle();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            atNegedge($sformatf("vec%0d", i));
            check($sformatf("vec%0d A outs", i), outsA(), int'(vecs[i].expA));
            check($sformatf("vec%0d B outs", i), outsB(), int'(vecs[i].expB));
            check($sformatf("vec%0d A stall", i), int'(stallCountA), vecs[i].expStallA);
            check($sformatf("vec%0d B stall", i), int'(stallCountB), vecs[i].expStallB);
            finishCycle();
        end

        // Branch wins over a live hazard; B's second pulse lands inside its flush window.
        setIdle();
        idexRd = 5'd4; idexRegwrite = 1'b1; ifidRn = 5'd4; ifidUsesRn = 1'b1;
        exBranchTaken = 1'b1;
        atNegedge("br0");
        check("br0 B outs", outsB(), 4'b1111);
        check("br0 B state", int'(stateB), 0);
        finishCycle();
        atNegedge("br1");
        check("br1 B outs", outsB(), 4'b1111);
        check("br1 B state", int'(stateB), 1);
        finishCycle();
        exBranchTaken = 1'b0;
        atNegedge("br2");
        check("br2 B outs", outsB(), 4'b1111);
        check("br2 B state", int'(stateB), 1);
        finishCycle();
        atNegedge("br3");
        check("br3 B outs", outsB(), 4'b0001);
        check("br3 B flush_count", int'(flushCountB), 1);
        check("br3 B stall unchanged", int'(stallCountB), 5);
        finishCycle();

        // Hazard held long enough to saturate the 4-bit counter, then reset mid-stall.
        for (int i = 0; i < 20; i++) runCycle("sat");
        atNegedge("sat end");
        check("sat B stall", int'(stallCountB), 15);
        finishCycle();
        reset = 1'b1;
        runCycle("rst mid stall");
        atNegedge("after rst");
        check("after rst B stall", int'(stallCountB), 0);
        check("after rst A stall", int'(stallCountA), 0);
        check("after rst B flush", int'(flushCountB), 0);
        check("after rst B state", int'(stateB), 2);
        check("after rst B pc_write", int'(pcWriteB), 0);
        finishCycle();
        reset = 1'b0;
        setIdle();
        runCycle("rel");

        // Reset lands on the first FLUSH cycle of B.
        exBranchTaken = 1'b1;
        runCycle("flush start");
        exBranchTaken = 1'b0;
        reset = 1'b1;
        atNegedge("flush mid");
        check("flush mid B state", int'(stateB), 1);
        finishCycle();
        atNegedge("flush abandoned");
        check("flush abandoned B state", int'(stateB), 2);
        check("flush abandoned B outs", outsB(), 4'b0011);
        finishCycle();
        reset = 1'b0;
        runCycle("rel2");

        for (int i = 0; i < 400; i++) begin
            ifidRn = rndReg(); ifidRm = rndReg();
            ifidUsesRn = 1'($urandom_range(0, 1)); ifidUsesRm = 1'($urandom_range(0, 1));
            idexRd = rndReg(); exmemRd = rndReg(); memwbRd = rndReg();
            idexRegwrite = 1'($urandom_range(0, 1));
            exmemRegwrite = 1'($urandom_range(0, 1));
            memwbRegwrite = 1'($urandom_range(0, 1));
            exBranchTaken = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 49) == 0);
            runCycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
